// File: rtl/top_module_core.sv
// k-mer frequency counter: counts every k-symbol window of a nucleotide stream,
// then scans all counters box-parallel to report the most frequent k-mer.
module top_module_core #(
  parameter int unsigned ADDR_LEN = 6,
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned BOX_IDX  = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          symbol,
  input  logic                BC_mode,
  output logic                done,
  output logic [ADDR_LEN-1:0] max_addr,
  output logic [DATA_LEN-1:0] max_count
);

  localparam int unsigned K    = ADDR_LEN / 2;
  localparam int unsigned VW   = $clog2(K + 1);
  localparam int unsigned SW   = ADDR_LEN - BOX_IDX;
  localparam int unsigned SPAN = 1 << SW;
  localparam int unsigned NBOX = 1 << BOX_IDX;
  localparam int unsigned NUM  = 1 << ADDR_LEN;

  localparam logic [VW-1:0]       KV       = VW'(K);
  localparam logic [SW-1:0]       ScanLast = SW'(SPAN - 1);
  localparam logic [DATA_LEN-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StCount, StScan, StDone} state_e;

  state_e              state_q;
  logic [ADDR_LEN-1:0] window_q;
  logic [VW-1:0]       vcnt_q;
  logic [SW-1:0]       scan_j_q;
  logic [ADDR_LEN-1:0] best_addr_q;
  logic [DATA_LEN-1:0] best_cnt_q;
  logic [DATA_LEN-1:0] cnt_q [NUM];

  logic [ADDR_LEN+1:0] window_ext;
  logic [ADDR_LEN-1:0] window_next;
  logic [VW-1:0]       vcnt_next;
  logic                window_full;

  // Window includes the current symbol, so it is full one symbol before vcnt saturates.
  always_comb begin
    window_ext  = {window_q, symbol};
    window_next = window_ext[ADDR_LEN-1:0];
    vcnt_next   = (vcnt_q == KV) ? KV : vcnt_q + 1'b1;
    window_full = (vcnt_next == KV);
  end

  function automatic logic beats(input logic [DATA_LEN-1:0] ca, input logic [ADDR_LEN-1:0] aa,
                                 input logic [DATA_LEN-1:0] cb, input logic [ADDR_LEN-1:0] ab);
    return (ca > cb) || ((ca == cb) && (aa < ab));
  endfunction

  logic [ADDR_LEN-1:0] t_addr [BOX_IDX+1][NBOX];
  logic [DATA_LEN-1:0] t_cnt  [BOX_IDX+1][NBOX];
  logic [ADDR_LEN-1:0] new_addr;
  logic [DATA_LEN-1:0] new_cnt;

  // Comparator tree over one entry per box, then merged with the running best.
  always_comb begin
    for (int l = 0; l <= int'(BOX_IDX); l++) begin
      for (int i = 0; i < int'(NBOX); i++) begin
        t_addr[l][i] = '0;
        t_cnt[l][i]  = '0;
      end
    end
    for (int b = 0; b < int'(NBOX); b++) begin
      t_addr[0][b] = ADDR_LEN'(b * int'(SPAN) + int'(scan_j_q));
      t_cnt[0][b]  = cnt_q[ADDR_LEN'(b * int'(SPAN) + int'(scan_j_q))];
    end
    for (int l = 0; l < int'(BOX_IDX); l++) begin
      for (int i = 0; i < int'(NBOX >> (l + 1)); i++) begin
        if (beats(t_cnt[l][2*i+1], t_addr[l][2*i+1], t_cnt[l][2*i], t_addr[l][2*i])) begin
          t_addr[l+1][i] = t_addr[l][2*i+1];
          t_cnt[l+1][i]  = t_cnt[l][2*i+1];
        end else begin
          t_addr[l+1][i] = t_addr[l][2*i];
          t_cnt[l+1][i]  = t_cnt[l][2*i];
        end
      end
    end
    if (beats(t_cnt[BOX_IDX][0], t_addr[BOX_IDX][0], best_cnt_q, best_addr_q)) begin
      new_addr = t_addr[BOX_IDX][0];
      new_cnt  = t_cnt[BOX_IDX][0];
    end else begin
      new_addr = best_addr_q;
      new_cnt  = best_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      window_q    <= '0;
      vcnt_q      <= '0;
      scan_j_q    <= '0;
      best_addr_q <= '0;
      best_cnt_q  <= '0;
      done        <= 1'b0;
      max_addr    <= '0;
      max_count   <= '0;
      for (int i = 0; i < int'(NUM); i++) cnt_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle, StCount: begin
          if (BC_mode) begin
            state_q  <= StCount;
            window_q <= window_next;
            vcnt_q   <= vcnt_next;
            if (window_full && (cnt_q[window_next] != CntMax)) begin
              cnt_q[window_next] <= cnt_q[window_next] + 1'b1;
            end
          end else if (state_q == StCount) begin
            state_q     <= StScan;
            scan_j_q    <= '0;
            best_addr_q <= '0;
            best_cnt_q  <= '0;
          end
        end
        StScan: begin
          best_addr_q <= new_addr;
          best_cnt_q  <= new_cnt;
          scan_j_q    <= scan_j_q + 1'b1;
          if (scan_j_q == ScanLast) begin
            state_q   <= StDone;
            done      <= 1'b1;
            max_addr  <= new_addr;
            max_count <= new_cnt;
          end
        end
        StDone: begin
          // Exit cycle only clears; its symbol is not counted.
          if (BC_mode) begin
            state_q  <= StCount;
            done     <= 1'b0;
            window_q <= '0;
            vcnt_q   <= '0;
            for (int i = 0; i < int'(NUM); i++) cnt_q[i] <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_top_module_core.sv
// Directed bench for top_module_core with hand-computed k-mer results.
module tb_top_module_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] symbol = 2'd0;
  logic       BC_mode = 1'b0;
  logic       done;
  logic [5:0] max_addr;
  logic [7:0] max_count;

  int vectors = 0;
  int miscompares = 0;

  top_module_core #(
    .ADDR_LEN(6),
    .DATA_LEN(8),
    .BOX_IDX (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .symbol   (symbol),
    .BC_mode  (BC_mode),
    .done     (done),
    .max_addr (max_addr),
    .max_count(max_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic bc, input logic [1:0] sym);
    BC_mode = bc;
    symbol  = sym;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(1'b0, 2'd0);
    step(1'b1, 2'd3);
    check("rst_done", done, 0);
    check("rst_addr", max_addr, 0);
    check("rst_count", max_count, 0);
    RST = 1'b0;
  endtask

  // Drops BC_mode, then counts edges until done rises (bounded).
  task automatic fall_and_wait(input string tag, input bit toggle);
    int cyc;
    cyc     = 0;
    BC_mode = 1'b0;
    symbol  = 2'd3;
    do begin
      @(posedge CLK);
      #1;
      cyc++;
      if (toggle) BC_mode = ~BC_mode;
      symbol = cyc[1:0];
    end while (!done && cyc < 40);
    BC_mode = 1'b0;
    check(tag, cyc, 9);
  endtask

  initial begin
    logic [1:0] seq;

    do_reset();

    // Long run of A: counter[0] saturates at 255.
    for (int i = 0; i < 2000; i++) step(1'b1, 2'd0);
    fall_and_wait("sat_latency", 1'b0);
    check("sat_addr", max_addr, 0);
    check("sat_count", max_count, 255);
    for (int i = 0; i < 3; i++) step(1'b0, 2'(i));
    check("hold_done", done, 1);
    check("hold_count", max_count, 255);

    // 0,1,2,3 x3: windows 6,27,44,49 with 6 and 27 tied at 3.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      seq = 2'(i % 4);
      step(1'b1, seq);
    end
    fall_and_wait("tie_latency", 1'b0);
    check("tie_done", done, 1);
    check("tie_addr", max_addr, 6);
    check("tie_count", max_count, 3);

    // Re-arm from DONE; the exit-cycle symbol is ignored, so only four 2s count.
    step(1'b1, 2'd2);
    check("rearm_done_low", done, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd2);
    fall_and_wait("rearm_latency_toggle", 1'b1);
    check("rearm_addr", max_addr, 42);
    check("rearm_count", max_count, 2);

    // Too few symbols for a full window.
    do_reset();
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    fall_and_wait("short_latency", 1'b0);
    check("short_done", done, 1);
    check("short_addr", max_addr, 0);
    check("short_count", max_count, 0);

    // Tie between addr 2 (box 0, j=2) and addr 9 (box 1, j=1): lower address wins.
    do_reset();
    step(1'b1, 2'd0);
    step(1'b1, 2'd0);
    step(1'b1, 2'd2);
    step(1'b1, 2'd1);
    fall_and_wait("xbox_latency", 1'b1);
    check("xbox_addr", max_addr, 2);
    check("xbox_count", max_count, 1);

    // Reset mid-scan, then a fresh run of 3,3,3.
    do_reset();
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    step(1'b0, 2'd0);
    step(1'b0, 2'd0);
    step(1'b0, 2'd0);
    RST = 1'b1;
    step(1'b0, 2'd0);
    check("midscan_rst_done", done, 0);
    check("midscan_rst_count", max_count, 0);
    RST = 1'b0;
    step(1'b0, 2'd0);
    step(1'b0, 2'd0);
    check("post_rst_idle_done", done, 0);
    step(1'b1, 2'd3);
    step(1'b1, 2'd3);
    step(1'b1, 2'd3);
    fall_and_wait("rerun_latency", 1'b0);
    check("rerun_addr", max_addr, 63);
    check("rerun_count", max_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
